// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES round index sequencer with first/last flags, abort and done pulse
// Hold support is compiled in only when AES_RND_HOLD_EN is defined; otherwise i_hold is ignored.
module aes_round_sequencer #(
  parameter int CNT_SIZE   = 4,
  parameter int ROUNDS_128 = 10,
  parameter int ROUNDS_192 = 12,
  parameter int ROUNDS_256 = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [1:0]          i_key_len,
  input  logic                i_hold,
  input  logic                i_abort,
  output logic                o_ready,
  output logic                o_busy,
  output logic [CNT_SIZE-1:0] o_round,
  output logic                o_first,
  output logic                o_last,
  output logic                o_done,
  output logic                o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_SIZE-1:0] round_q;
  logic [CNT_SIZE-1:0] nr_q;
  logic [CNT_SIZE-1:0] nr_d;
  logic                err_q;
  logic                hold_w;

`ifdef AES_RND_HOLD_EN
  assign hold_w = i_hold;
`else
  localparam logic HOLD_EN = 1'b0;
  assign hold_w = HOLD_EN & i_hold;
`endif

  always_comb begin
    nr_d = CNT_SIZE'(ROUNDS_128);
    case (i_key_len)
      2'b01:   nr_d = CNT_SIZE'(ROUNDS_192);
      2'b10:   nr_d = CNT_SIZE'(ROUNDS_256);
      default: nr_d = CNT_SIZE'(ROUNDS_128);
    endcase
  end

  // Abort outranks both start (in IDLE) and hold (in RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      nr_q    <= CNT_SIZE'(ROUNDS_128);
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            if (i_key_len == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              nr_q    <= nr_d;
              round_q <= '0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_abort) begin
            state_q <= S_IDLE;
            round_q <= '0;
          end else if (!hold_w) begin
            if (round_q == nr_q) begin
              state_q <= S_DONE;
              round_q <= '0;
            end else begin
              round_q <= round_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          round_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          round_q <= '0;
        end
      endcase
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_busy  = (state_q == S_RUN);
  assign o_round = round_q;
  assign o_first = (state_q == S_RUN) && (round_q == '0);
  assign o_last  = (state_q == S_RUN) && (round_q == nr_q);
  assign o_done  = (state_q == S_DONE);
  assign o_err   = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - scoreboard bench for aes_round_sequencer
// Honours AES_RND_HOLD_EN to pick the expected hold behaviour.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_key_len = 2'b00;
  logic       i_hold = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_ready, o_busy, o_first, o_last, o_done, o_err;
  logic [3:0] o_round;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_key_len (i_key_len),
    .i_hold    (i_hold),
    .i_abort   (i_abort),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_round   (o_round),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [3:0] round;
    logic       first;
    logic       last;
    logic       done;
    logic       err;
  } obs_t;

  obs_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string scen = "init";

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", scen, tag, act, exp);
    end
  endtask

  function automatic obs_t idle_o(input bit err);
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    o.err = err;
    return o;
  endfunction

  function automatic obs_t run_o(input int r, input int nr);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.round = 4'(r);
    o.first = (r == 0);
    o.last = (r == nr);
    return o;
  endfunction

  function automatic obs_t done_o();
    obs_t o;
    o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
  task automatic step(input bit s, input logic [1:0] k, input bit h, input bit a, input bit r,
                      input obs_t e);
    obs_t got;
    i_start = s; i_key_len = k; i_hold = h; i_abort = a; rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    check("ready", 32'(o_ready), 32'(got.ready));
    check("busy",  32'(o_busy),  32'(got.busy));
    check("round", 32'(o_round), 32'(got.round));
    check("first", 32'(o_first), 32'(got.first));
    check("last",  32'(o_last),  32'(got.last));
    check("done",  32'(o_done),  32'(got.done));
    check("err",   32'(o_err),   32'(got.err));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, idle_o(0));
  endtask

  // Full start-to-idle sequence; noise drives stray starts with random key lengths.
  task automatic run_full(input logic [1:0] key, input int nr, input bit noise, input bit abort_done);
    step(1, key, 0, 0, 0, run_o(0, nr));
    for (int r = 1; r <= nr; r++)
      step(noise, noise ? 2'($urandom_range(3)) : key, 0, 0, 0, run_o(r, nr));
    step(noise, noise ? 2'b11 : key, 0, 0, 0, done_o());
    step(noise, noise ? 2'b11 : 2'b00, 0, abort_done, 0, idle_o(0));
  endtask

  bit hold_en;

  initial begin
`ifdef AES_RND_HOLD_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    scen = "reset";
    step(0, 2'b00, 0, 0, 1, idle_o(0));
    step(0, 2'b00, 0, 0, 1, idle_o(0));
    idle_steps(2);

    scen = "aes128";
    run_full(2'b00, 10, 0, 0);
    idle_steps(1);

    scen = "aes256_hold";
    begin
      int r;
      step(1, 2'b10, 0, 0, 0, run_o(0, 14));
      for (r = 1; r <= 5; r++) step(0, 2'b00, 0, 0, 0, run_o(r, 14));
      r = 5;
      for (int i = 0; i < 3; i++) begin
        if (!hold_en) r++;
        step(0, 2'b00, 1, 0, 0, run_o(r, 14));
      end
      while (r < 14) begin
        r++;
        step(0, 2'b00, 0, 0, 0, run_o(r, 14));
      end
      step(0, 2'b00, 0, 0, 0, done_o());
      idle_steps(1);
    end

    scen = "abort192";
    step(1, 2'b01, 0, 0, 0, run_o(0, 12));
    for (int r = 1; r <= 7; r++) step(0, 2'b00, 0, 0, 0, run_o(r, 12));
    step(0, 2'b00, 1, 1, 0, idle_o(0));
    idle_steps(16);

    scen = "illegal";
    step(1, 2'b11, 0, 0, 0, idle_o(1));
    step(0, 2'b00, 0, 0, 0, idle_o(0));
    run_full(2'b00, 10, 0, 1);

    scen = "ignored";
    run_full(2'b01, 12, 1, 0);
    step(1, 2'b10, 0, 1, 0, idle_o(0));
    step(1, 2'b11, 0, 1, 0, idle_o(0));
    idle_steps(1);

    scen = "reset_mid";
    step(1, 2'b00, 0, 0, 0, run_o(0, 10));
    for (int r = 1; r <= 4; r++) step(0, 2'b00, 0, 0, 0, run_o(r, 10));
    step(0, 2'b00, 0, 0, 1, idle_o(0));
    idle_steps(3);
    run_full(2'b10, 14, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
